imem_fetch: RTL and testbench

- Instruction-fetch initiator that drives the PC/select side of the instruction memory and captures each returned 23-bit instruction word.
- Buffers fetched words in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles start, branch redirect (with flush) and halt detection.
- Sits between the instruction memory (combinational read) and the decode stage of the vector processor.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/imem_fetch.sv | 128 ++++++++++++
 tb/tb_imem_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch unit.
// Imported by the fetch top level; the struct documents the layout of one FIFO entry.
package fetch_pkg;

  localparam int unsigned PC_W_DEF    = 16;
  localparam int unsigned INSTR_W_DEF = 23;
  localparam int unsigned DEPTH_DEF   = 2;

  localparam logic [INSTR_W_DEF-1:0] HALT_WORD_DEF = 23'h7FFFFF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } fetch_state_t;

  // Entry layout as packed into the FIFO: PC in the upper bits, instruction below.
  typedef struct packed {
    logic [PC_W_DEF-1:0]    pc;
    logic [INSTR_W_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} entries.
// Flush empties it in one cycle; the head reads as zero while empty.
module fetch_fifo #(
  parameter int unsigned WIDTH = 39,
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [WIDTH-1:0]             i_data,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_pop   = i_pop && !w_empty && !i_flush;
  assign w_push  = i_push && (!w_full || w_pop) && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/imem_fetch.sv
// Instruction-fetch initiator: drives the imem PC/select, buffers returned words
// and hands them to decode over valid/ready, with redirect-flush and halt detection.
module imem_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_W      = PC_W_DEF,
  parameter int unsigned         INSTR_W   = INSTR_W_DEF,
  parameter int unsigned         DEPTH     = DEPTH_DEF,
  parameter logic [INSTR_W-1:0]  HALT_WORD = INSTR_W'(HALT_WORD_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         prog_sel,
  output logic [PC_W-1:0]    imem_pc,
  output logic [1:0]         imem_select,
  input  logic [INSTR_W-1:0] imem_instruction,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               busy,
  output logic               halted
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned EW = PC_W + INSTR_W;

  fetch_state_t r_state;
  fetch_state_t w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [1:0]      r_sel;
  logic [1:0]      w_sel_nxt;

  logic          w_redirect;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic          w_valid;
  logic [CW-1:0] w_count;
  logic [EW-1:0] w_head;

  assign w_valid    = (w_count != '0);
  assign w_redirect = redirect_valid && (r_state != IDLE);
  // Decode must not consume a word shown alongside a redirect; the flush drops it.
  assign w_pop      = w_valid && instr_ready && !w_redirect;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sel_nxt   = r_sel;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
          w_sel_nxt   = prog_sel;
        end
      end
      RUN: begin
        if (w_redirect) begin
          w_flush  = 1'b1;
          w_pc_nxt = redirect_pc;
        end else if ((w_count < CW'(DEPTH)) || w_pop) begin
          w_push   = 1'b1;
          w_pc_nxt = r_pc + PC_W'(1);
          if (imem_instruction == HALT_WORD) begin
            w_state_nxt = HALTED;
          end
        end
      end
      HALTED: begin
        if (w_redirect) begin
          w_flush     = 1'b1;
          w_state_nxt = RUN;
          w_pc_nxt    = redirect_pc;
        end else if (start) begin
          w_state_nxt = RUN;
          w_pc_nxt    = '0;
          w_sel_nxt   = prog_sel;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_data  ({r_pc, imem_instruction}),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign imem_pc     = r_pc;
  assign imem_select = r_sel;
  assign instr_valid = w_valid;
  assign instr_pc    = w_head[EW-1:INSTR_W];
  assign instr       = w_head[INSTR_W-1:0];
  assign busy        = (r_state == RUN);
  assign halted      = (r_state == HALTED);

endmodule

// File: tb/tb_imem_fetch.sv
// Directed, table-driven bench for imem_fetch with a behavioural imem
// (word k+100 at PC k, HALT_WORD at PC 5).
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  prog_sel;
  logic [15:0] imem_pc;
  logic [1:0]  imem_select;
  logic [22:0] imem_instruction;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [22:0] instr;
  logic [15:0] instr_pc;
  logic        busy;
  logic        halted;

  int checks = 0;
  int failures = 0;
  int row = 0;

  always #5 clk = ~clk;

  imem_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .prog_sel         (prog_sel),
    .imem_pc          (imem_pc),
    .imem_select      (imem_select),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr            (instr),
    .instr_pc         (instr_pc),
    .busy             (busy),
    .halted           (halted)
  );

  assign imem_instruction = (imem_pc == 16'd5) ? 23'h7FFFFF : (23'(imem_pc) + 23'd100);

  typedef struct {
    logic        start;
    logic [1:0]  sel;
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        ev;
    logic [22:0] ei;
    logic [15:0] ep;
    logic [15:0] eipc;
    logic [1:0]  esel;
    logic        eb;
    logic        eh;
  } vec_t;

  vec_t vt [29];

  function automatic vec_t mk(logic s, logic [1:0] sl, logic r, logic rv, logic [15:0] rpc,
                              logic ev, logic [22:0] ei, logic [15:0] ep, logic [15:0] eipc,
                              logic [1:0] esel, logic eb, logic eh);
    vec_t v;
    v.start = s; v.sel = sl; v.rdy = r; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.ei = ei; v.ep = ep; v.eipc = eipc; v.esel = esel; v.eb = eb; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d actual=%h required=%h", name, row, act, exp);
    end
  endtask

  task automatic chk_all(input logic ev, input logic [22:0] ei, input logic [15:0] ep,
                         input logic [15:0] eipc, input logic [1:0] esel, input logic eb,
                         input logic eh);
    chk("instr_valid", 32'(instr_valid), 32'(ev));
    chk("instr", 32'(instr), 32'(ei));
    chk("instr_pc", 32'(instr_pc), 32'(ep));
    chk("imem_pc", 32'(imem_pc), 32'(eipc));
    chk("imem_select", 32'(imem_select), 32'(esel));
    chk("busy", 32'(busy), 32'(eb));
    chk("halted", 32'(halted), 32'(eh));
  endtask

  initial begin
    // start, sel, rdy, rv, rpc | valid, instr, instr_pc, imem_pc, sel, busy, halted
    vt[0]  = mk(1, 2'd1, 1, 0, 16'h0,    0, 23'd0,       16'h0,    16'h0,    2'd0, 0, 0);
    vt[1]  = mk(0, 2'd0, 1, 0, 16'h0,    0, 23'd0,       16'h0,    16'h0,    2'd1, 1, 0);
    vt[2]  = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd100,     16'h0,    16'h1,    2'd1, 1, 0);
    vt[3]  = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd101,     16'h1,    16'h2,    2'd1, 1, 0);
    vt[4]  = mk(1, 2'd3, 1, 0, 16'h0,    1, 23'd102,     16'h2,    16'h3,    2'd1, 1, 0);
    vt[5]  = mk(0, 2'd0, 0, 0, 16'h0,    1, 23'd103,     16'h3,    16'h4,    2'd1, 1, 0);
    vt[6]  = mk(0, 2'd0, 0, 1, 16'h0040, 1, 23'd103,     16'h3,    16'h5,    2'd1, 1, 0);
    vt[7]  = mk(0, 2'd0, 0, 0, 16'h0,    0, 23'd0,       16'h0,    16'h0040, 2'd1, 1, 0);
    vt[8]  = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd164,     16'h0040, 16'h0041, 2'd1, 1, 0);
    vt[9]  = mk(0, 2'd0, 1, 1, 16'h0,    1, 23'd165,     16'h0041, 16'h0042, 2'd1, 1, 0);
    vt[10] = mk(0, 2'd0, 1, 0, 16'h0,    0, 23'd0,       16'h0,    16'h0,    2'd1, 1, 0);
    vt[11] = mk(0, 2'd0, 0, 0, 16'h0,    1, 23'd100,     16'h0,    16'h1,    2'd1, 1, 0);
    vt[12] = mk(0, 2'd0, 0, 0, 16'h0,    1, 23'd100,     16'h0,    16'h2,    2'd1, 1, 0);
    vt[13] = mk(0, 2'd0, 0, 0, 16'h0,    1, 23'd100,     16'h0,    16'h2,    2'd1, 1, 0);
    vt[14] = mk(0, 2'd0, 0, 0, 16'h0,    1, 23'd100,     16'h0,    16'h2,    2'd1, 1, 0);
    vt[15] = mk(0, 2'd0, 0, 0, 16'h0,    1, 23'd100,     16'h0,    16'h2,    2'd1, 1, 0);
    vt[16] = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd100,     16'h0,    16'h2,    2'd1, 1, 0);
    vt[17] = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd101,     16'h1,    16'h3,    2'd1, 1, 0);
    vt[18] = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd102,     16'h2,    16'h4,    2'd1, 1, 0);
    vt[19] = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd103,     16'h3,    16'h5,    2'd1, 1, 0);
    vt[20] = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd104,     16'h4,    16'h6,    2'd1, 0, 1);
    vt[21] = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'h7FFFFF,  16'h5,    16'h6,    2'd1, 0, 1);
    vt[22] = mk(0, 2'd0, 1, 0, 16'h0,    0, 23'd0,       16'h0,    16'h6,    2'd1, 0, 1);
    vt[23] = mk(1, 2'd2, 1, 1, 16'h0010, 0, 23'd0,       16'h0,    16'h6,    2'd1, 0, 1);
    vt[24] = mk(0, 2'd0, 1, 0, 16'h0,    0, 23'd0,       16'h0,    16'h0010, 2'd1, 1, 0);
    vt[25] = mk(0, 2'd0, 1, 1, 16'hFFFF, 1, 23'd116,     16'h0010, 16'h0011, 2'd1, 1, 0);
    vt[26] = mk(0, 2'd0, 1, 0, 16'h0,    0, 23'd0,       16'h0,    16'hFFFF, 2'd1, 1, 0);
    vt[27] = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd65635,   16'hFFFF, 16'h0,    2'd1, 1, 0);
    vt[28] = mk(0, 2'd0, 1, 0, 16'h0,    1, 23'd100,     16'h0,    16'h1,    2'd1, 1, 0);

    rst = 1'b1;
    start = 1'b0;
    prog_sel = 2'd0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0;
    instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 29; i++) begin
      row = i;
      start = vt[i].start;
      prog_sel = vt[i].sel;
      instr_ready = vt[i].rdy;
      redirect_valid = vt[i].rv;
      redirect_pc = vt[i].rpc;
      #1;
      chk_all(vt[i].ev, vt[i].ei, vt[i].ep, vt[i].eipc, vt[i].esel, vt[i].eb, vt[i].eh);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between clock edges while the FIFO holds entries.
    row = 100;
    start = 1'b0;
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk_all(0, 23'd0, 16'h0, 16'h0, 2'd0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      row = 101 + i;
      #1;
      chk_all(0, 23'd0, 16'h0, 16'h0, 2'd0, 0, 0);
      @(posedge clk);
      #1;
    end

    // Restart from IDLE with a different bank select.
    row = 110;
    start = 1'b1;
    prog_sel = 2'd2;
    #1;
    @(posedge clk);
    #1 start = 1'b0;
    prog_sel = 2'd0;
    row = 111;
    #1;
    chk_all(0, 23'd0, 16'h0, 16'h0, 2'd2, 1, 0);
    @(posedge clk);
    #1;
    row = 112;
    chk_all(1, 23'd100, 16'h0, 16'h1, 2'd2, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog row=%0d actual=timeout required=finish", row);
    $fatal(1, "watchdog expired");
  end

endmodule
